spi_status_tx: RTL and testbench

- Return-path SPI responder. Drives MISO so the host can read controller status over the same chip-select and SPI clock that it uses to write PWM targets.
- Accumulates sticky pwm_done and crc_error events from the address decoder into a 24-bit CRC-protected status frame.
- Shifts the frame out MSB-first in SPI mode 0.
- Runs entirely on fpga_clock. spi_clock and cs_n are oversampled through synchronizers.

---
 rtl/spi_pkg.sv | 38 +++
 rtl/spi_status_tx_if.sv | 24 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_status_tx.sv | 125 ++++++++++++
 tb/tb_spi_status_tx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants, state encoding and CRC for the SPI status return path.
// Frame: done snapshot, error snapshot, sequence number, zero pad, CRC-4.
package spi_pkg;

    localparam int FRAME_W  = 24;
    localparam int DONE_MSB = 23;
    localparam int DONE_LSB = 12;
    localparam int ERR_BIT  = 11;
    localparam int SEQ_MSB  = 10;
    localparam int SEQ_LSB  = 8;
    localparam int CRC_MSB  = 3;
    localparam int CRC_LSB  = 0;

    localparam logic [3:0] CRC4_POLY = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        HOLD,
        ABORT
    } state_t;

    // MSB-first, zero seed, no final inversion
    function automatic logic [3:0] crc4(input logic [19:0] d);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 19; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ CRC4_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_status_tx_if.sv
// SPI bus between the host and the status responder.
// master = host side, slave = responder side.
interface spi_status_tx_if;

    logic spi_clock;
    logic cs_n;
    logic miso;
    logic miso_oe;

    modport master (
        output spi_clock,
        output cs_n,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  spi_clock,
        input  cs_n,
        output miso,
        output miso_oe
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer followed by a rise/fall edge detector.
// RST_VAL is the idle level of the synchronized input.
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic fpga_clock,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sr;
    logic                   prev;
    logic                   lvl;

    assign lvl = sr[SYNC_STAGES-1];

    always_ff @(posedge fpga_clock or negedge reset_n) begin
        if (!reset_n) begin
            sr   <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], din};
            prev <= lvl;
        end
    end

    assign rise = lvl & ~prev;
    assign fall = ~lvl & prev;

endmodule

// File: rtl/spi_status_tx.sv
// SPI mode-0 status responder: sticky pwm_done/crc_error events are
// snapshotted into a CRC-protected 24-bit frame and shifted out on MISO.
module spi_status_tx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             fpga_clock,
    input  logic             reset_n,
    spi_status_tx_if.slave   spi,
    input  logic [11:0]      pwm_done,
    input  logic             crc_error,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);
    localparam logic [4:0] FULL_CNT = 5'(FRAME_W);

    state_t               state, nxt;
    logic                 sclk_rise, sclk_fall;
    logic                 cs_rise, cs_fall;
    logic [FRAME_W-1:0]   shreg;
    logic [FRAME_W-1:0]   frame_now;
    logic [4:0]           bit_cnt;
    logic [2:0]           seq;
    logic [11:0]          done_sticky, snap_done, done_clr;
    logic                 err_sticky, snap_err, err_clr;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .fpga_clock (fpga_clock),
        .reset_n    (reset_n),
        .din        (spi.spi_clock),
        .rise       (sclk_rise),
        .fall       (sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .fpga_clock (fpga_clock),
        .reset_n    (reset_n),
        .din        (spi.cs_n),
        .rise       (cs_rise),
        .fall       (cs_fall)
    );

    always_comb begin
        frame_now                   = '0;
        frame_now[DONE_MSB:DONE_LSB] = done_sticky;
        frame_now[ERR_BIT]           = err_sticky;
        frame_now[SEQ_MSB:SEQ_LSB]   = seq;
        frame_now[CRC_MSB:CRC_LSB]   = crc4(frame_now[FRAME_W-1:CRC_MSB+1]);
    end

    // only the bits that were actually reported get cleared; new events win
    assign done_clr = (state == DONE) ? snap_done : '0;
    assign err_clr  = (state == DONE) ? snap_err  : 1'b0;

    always_ff @(posedge fpga_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt        = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE:  if (cs_fall) nxt = LOAD;
            LOAD:  nxt = cs_rise ? ABORT : SHIFT;
            SHIFT: begin
                if (sclk_rise && bit_cnt == LAST_BIT) nxt = DONE;
                else if (cs_rise)                     nxt = ABORT;
            end
            DONE: begin
                frame_done = 1'b1;
                nxt        = cs_rise ? IDLE : HOLD;
            end
            HOLD:  if (cs_rise) nxt = IDLE;
            ABORT: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clock or negedge reset_n) begin
        if (!reset_n) begin
            done_sticky <= '0;
            err_sticky  <= 1'b0;
            snap_done   <= '0;
            snap_err    <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            seq         <= '0;
        end else begin
            done_sticky <= (done_sticky & ~done_clr) | pwm_done;
            err_sticky  <= (err_sticky & ~err_clr) | crc_error;
            unique case (state)
                LOAD: begin
                    snap_done <= done_sticky;
                    snap_err  <= err_sticky;
                    shreg     <= frame_now;
                    bit_cnt   <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) bit_cnt <= bit_cnt + 5'd1;
                    if (sclk_fall && bit_cnt < FULL_CNT)
                        shreg <= {shreg[FRAME_W-2:0], 1'b0};
                end
                DONE:    seq <= seq + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        spi.miso = 1'b0;
        unique case (state)
            LOAD:    spi.miso = frame_now[FRAME_W-1];
            SHIFT:   spi.miso = shreg[FRAME_W-1];
            default: spi.miso = 1'b0;
        endcase
    end

    assign spi.miso_oe = (state != IDLE);
    assign tx_busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_status_tx.sv
// Directed bench for spi_status_tx with a frame-level reference model.
// A negedge monitor checks enable/busy/frame_done levels every cycle.
module tb_spi_status_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pwm_done = '0;
    logic        crc_error = 1'b0;
    logic        tx_busy;
    logic        frame_done;

    spi_status_tx_if bus ();

    spi_status_tx #(.SYNC_STAGES(2)) dut (
        .fpga_clock (clk),
        .reset_n    (rst_n),
        .spi        (bus),
        .pwm_done   (pwm_done),
        .crc_error  (crc_error),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int fd_cnt = 0;

    logic [11:0] m_done = '0;
    logic        m_err  = 1'b0;
    int          m_seq  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // remainder of d*x^4 divided by x^4+x+1
    function automatic logic [3:0] crc_div(input logic [19:0] d);
        logic [23:0] v;
        v = {d, 4'h0};
        for (int i = 23; i >= 4; i--)
            if (v[i]) v = v ^ (24'h13 << (i - 4));
        return v[3:0];
    endfunction

    function automatic logic [23:0] model_frame();
        logic [19:0] d;
        d = {m_done, m_err, 3'(m_seq), 4'h0};
        return {d, crc_div(d)};
    endfunction

    int  lowc = 0;
    int  highc = 0;
    logic prev_fd = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            lowc    = 0;
            highc   = 0;
            prev_fd = 1'b0;
        end else begin
            if (bus.cs_n) begin
                highc++;
                lowc = 0;
            end else begin
                lowc++;
                highc = 0;
            end
            if (lowc >= 5) begin
                chk("oe_active", 32'(bus.miso_oe), 32'd1);
                chk("busy_active", 32'(tx_busy), 32'd1);
            end
            if (highc >= 5) begin
                chk("oe_idle", 32'(bus.miso_oe), 32'd0);
                chk("busy_idle", 32'(tx_busy), 32'd0);
                chk("fdone_idle", 32'(frame_done), 32'd0);
            end
            if (frame_done) begin
                fd_cnt++;
                chk("fdone_width", 32'(prev_fd), 32'd0);
            end
            prev_fd = frame_done;
        end
    end

    task automatic xfer(input int nbits, output logic [31:0] cap);
        cap = '0;
        bus.cs_n = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            cap = {cap[30:0], bus.miso};
            bus.spi_clock = 1'b1;
            tick(8);
            bus.spi_clock = 1'b0;
            tick(8);
        end
        bus.cs_n = 1'b1;
        tick(4);
        chk("oe_drop", 32'(bus.miso_oe), 32'd0);
        chk("busy_drop", 32'(tx_busy), 32'd0);
        tick(8);
    endtask

    task automatic do_frame(input int nbits, input string tag,
                            output logic [23:0] got);
        logic [31:0] cap;
        logic [23:0] exp;
        int          fd0;
        int          extra;
        exp = model_frame();
        fd0 = fd_cnt;
        xfer(nbits, cap);
        if (nbits >= 24) begin
            extra = nbits - 24;
            got = 24'(cap >> extra);
            chk({tag, "_frame"}, 32'(got), 32'(exp));
            if (extra > 0)
                chk({tag, "_tail"}, cap & ((32'd1 << extra) - 32'd1), 32'd0);
            chk({tag, "_fdone"}, 32'(fd_cnt - fd0), 32'd1);
            m_done = (m_done & ~exp[23:12]) | pwm_done;
            m_err  = (m_err & ~exp[11]) | crc_error;
            m_seq  = (m_seq + 1) % 8;
        end else begin
            got = 24'(cap);
            chk({tag, "_part"}, cap, 32'(exp >> (24 - nbits)));
            chk({tag, "_nofdone"}, 32'(fd_cnt - fd0), 32'd0);
        end
    endtask

    task automatic pulse_done(input logic [11:0] v);
        pwm_done = v;
        tick(1);
        pwm_done = '0;
        m_done = m_done | v;
        tick(2);
    endtask

    logic [23:0] got;
    logic [23:0] first_try;

    initial begin
        bus.cs_n = 1'b1;
        bus.spi_clock = 1'b0;
        tick(3);
        chk("rst_miso", 32'(bus.miso), 32'd0);
        chk("rst_oe", 32'(bus.miso_oe), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);

        chk("pkg_crc_a", 32'(spi_pkg::crc4(20'h00F10)), 32'(crc_div(20'h00F10)));
        chk("pkg_crc_b", 32'(spi_pkg::crc4(20'hABCDE)), 32'(crc_div(20'hABCDE)));
        chk("pkg_crc_c", 32'(spi_pkg::crc4(20'h80001)), 32'(crc_div(20'h80001)));

        rst_n = 1'b1;
        tick(6);

        do_frame(24, "empty", got);
        chk("empty_lit", 32'(got), 32'h000000);

        pulse_done(12'h00F);
        do_frame(24, "done0f", got);
        chk("done0f_lit", 32'(got), 32'h00F10F);
        do_frame(24, "cleared", got);
        chk("cleared_lit", 32'(got), 32'h00020A);

        crc_error = 1'b1;
        m_err = 1'b1;
        tick(2);
        do_frame(24, "err_hold", got);
        crc_error = 1'b0;
        tick(2);
        do_frame(24, "err_kept", got);
        chk("err_kept_bit", 32'(got[11]), 32'd1);
        do_frame(24, "err_clr", got);
        chk("err_clr_bit", 32'(got[11]), 32'd0);

        pulse_done(12'hA50);
        do_frame(10, "abort", first_try);
        do_frame(24, "retry", got);
        chk("retry_prefix", 32'(got[23:14]), 32'(first_try[9:0]));

        do_frame(32, "long", got);

        for (int i = 0; i < 8; i++) begin
            if (i == 3) pulse_done(12'h801);
            do_frame(24, "seqloop", got);
        end

        pulse_done(12'h0F0);
        bus.cs_n = 1'b0;
        tick(8);
        for (int i = 0; i < 5; i++) begin
            bus.spi_clock = 1'b1;
            tick(8);
            bus.spi_clock = 1'b0;
            tick(8);
        end
        chk("pre_rst_oe", 32'(bus.miso_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", 32'(bus.miso), 32'd0);
        chk("mid_rst_oe", 32'(bus.miso_oe), 32'd0);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        bus.cs_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        m_done = '0;
        m_err = 1'b0;
        m_seq = 0;
        tick(8);
        do_frame(24, "post_rst", got);
        chk("post_rst_lit", 32'(got), 32'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
